// File: rtl/oai222_char_seq.sv
// oai222_char_seq: stimulus sequencer and checker for one OAI222 cell.
// Sweeps all 64 input vectors onto IN1..IN6 for PASSES passes. Each vector is
// held for DWELL cycles, and the returned QN is sampled on the last cycle of
// that window. The sample is checked against a golden model, and the block
// counts mismatches and toggles of the sampled output.
// Build option: define OAI222_CHAR_SEQ_GRAY_EN to sweep in Gray order
// (one input toggles per step); otherwise the sweep is in binary order.
module oai222_char_seq #(
  parameter int DWELL  = 4,
  parameter int PASSES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             QN_IN,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             IN4,
  output logic             IN5,
  output logic             IN6,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [5:0]       FAIL_VEC,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] TOGGLE_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] PASS_LAST  = 4'(PASSES - 1);
  localparam logic [5:0] STEP_LAST  = 6'd63;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] step;
  logic [3:0] pass;
  logic [7:0] dwell;
  logic       qn_prev_p1;
  logic       have_prev_p1;

  logic [5:0] vec_cur;
  logic       exp_qn;
  logic       accept;
  logic       smp_now;
  logic       mis;
  logic       tog;
  logic       last_smp;
  logic [5:0] in_drv;

  // Step index to applied vector; Gray order is a build-time option.
  function automatic logic [5:0] vec_of(input logic [5:0] s);
`ifdef OAI222_CHAR_SEQ_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  // Ideal OAI222 response for one vector (IN1 = bit 0 ... IN6 = bit 5).
  function automatic logic golden(input logic [5:0] v);
    return ~((v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]));
  endfunction

  // Saturating increment for the activity and error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Sample decision, check and toggle detection for the current cycle.
  always_comb begin
    vec_cur  = vec_of(step);
    exp_qn   = golden(vec_cur);
    accept   = (state == IDLE) && START && !ABORT;
    smp_now  = (state == DRIVE) && !ABORT && (dwell == DWELL_LAST);
    mis      = smp_now && (QN_IN != exp_qn);
    tog      = smp_now && have_prev_p1 && (QN_IN != qn_prev_p1);
    last_smp = smp_now && (step == STEP_LAST) && (pass == PASS_LAST);
  end

  // Next-state logic; ABORT beats START in IDLE and ends a run in DRIVE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE: begin
        if (ABORT)         state_nxt = IDLE;
        else if (last_smp) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cell drive and status outputs decoded from the state register.
  always_comb begin
    in_drv = (state == DRIVE) ? vec_cur : 6'd0;
    {IN6, IN5, IN4, IN3, IN2, IN1} = in_drv;
    BUSY = (state == DRIVE);
    DONE = (state == FINISH);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result flags and counters: cleared on an accepted START, updated per sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR          <= 1'b0;
      FAIL_VEC     <= 6'd0;
      ERR_CNT      <= '0;
      TOGGLE_CNT   <= '0;
      have_prev_p1 <= 1'b0;
    end else if (accept) begin
      ERR          <= 1'b0;
      FAIL_VEC     <= 6'd0;
      ERR_CNT      <= '0;
      TOGGLE_CNT   <= '0;
      have_prev_p1 <= 1'b0;
    end else if (smp_now) begin
      have_prev_p1 <= 1'b1;
      if (mis) begin
        ERR_CNT <= sat_inc(ERR_CNT);
        if (!ERR) begin
          ERR      <= 1'b1;
          FAIL_VEC <= vec_cur;
        end
      end
      if (tog) TOGGLE_CNT <= sat_inc(TOGGLE_CNT);
    end
  end

  // Sweep position and sample history; reinitialised by every accepted START.
  always_ff @(posedge CLK) begin
    if (accept) begin
      step  <= 6'd0;
      pass  <= 4'd0;
      dwell <= 8'd0;
    end else if ((state == DRIVE) && !ABORT) begin
      if (smp_now) begin
        dwell      <= 8'd0;
        step       <= step + 6'd1;
        qn_prev_p1 <= QN_IN;
        if (step == STEP_LAST) pass <= pass + 4'd1;
      end else begin
        dwell <= dwell + 8'd1;
      end
    end
  end

endmodule
